// File: rtl/sme_feeder.sv
// sme_feeder: host-side loader and serialiser for the string-matching engine (SME)
// Buffers one string (STR_MAX bytes) and one pattern (PAT_MAX bytes), streams them onto the
// SME byte interface, waits for the SME result and returns it as a one-cycle pulse.
// Ports: clk, reset (sync, active-high); str_we/pat_we/wdata/load_clr host load side;
//   start/busy transaction control; chardata/isstring/ispattern to SME;
//   sme_valid/sme_match/sme_index from SME; res_valid/res_match/res_index/res_timeout result.
// Macro SME_FEEDER_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT cycles.
module sme_feeder #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8
`ifdef SME_FEEDER_TIMEOUT_EN
   , parameter int TIMEOUT = 64
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       str_we,
   input  logic       pat_we,
   input  logic [7:0] wdata,
   input  logic       load_clr,
   input  logic       start,
   output logic       busy,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       sme_valid,
   input  logic       sme_match,
   input  logic [4:0] sme_index,
   output logic       res_valid,
   output logic       res_match,
   output logic [4:0] res_index,
   output logic       res_timeout
);
   localparam int SW = $clog2(STR_MAX + 1);
   localparam int PW = $clog2(PAT_MAX + 1);
   localparam int SA = $clog2(STR_MAX);
   localparam int PA = $clog2(PAT_MAX);
   localparam logic [SW-1:0] SMAX = SW'(STR_MAX);
   localparam logic [PW-1:0] PMAX = PW'(PAT_MAX);
   typedef enum logic [2:0] {IDLE, SEND_STR, GAP, SEND_PAT, WAIT, DONE} state_t;
   state_t state;
   logic [7:0] str_buf [STR_MAX];
   logic [7:0] pat_buf [PAT_MAX];
   logic [SW-1:0] str_len, idx;
   logic [PW-1:0] pat_len;
   logic str_dirty;
`ifdef SME_FEEDER_TIMEOUT_EN
   logic [6:0] wcnt;
`else
   assign res_timeout = 1'b0;
`endif
   assign busy = state != IDLE;
   // state names the phase currently visible on the SME outputs; idx is the next byte to emit
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         str_len <= '0;
         pat_len <= '0;
         str_dirty <= 1'b0;
         idx <= '0;
         chardata <= 8'd0;
         isstring <= 1'b0;
         ispattern <= 1'b0;
         res_valid <= 1'b0;
         res_match <= 1'b0;
         res_index <= 5'd0;
`ifdef SME_FEEDER_TIMEOUT_EN
         res_timeout <= 1'b0;
         wcnt <= 7'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (load_clr) begin
                  str_len <= '0;
                  pat_len <= '0;
                  str_dirty <= 1'b0;
               end else begin
                  if (str_we && str_len != SMAX) begin
                     str_buf[str_len[SA-1:0]] <= wdata;
                     str_len <= str_len + SW'(1);
                     str_dirty <= 1'b1;
                  end
                  if (pat_we && pat_len != PMAX) begin
                     pat_buf[pat_len[PA-1:0]] <= wdata;
                     pat_len <= pat_len + PW'(1);
                  end
               end
               if (start && pat_len != '0) begin
                  idx <= SW'(1);
                  if (str_dirty && str_len != '0) begin
                     state <= SEND_STR;
                     isstring <= 1'b1;
                     chardata <= str_buf[0];
                     str_dirty <= 1'b0;
                  end else begin
                     state <= SEND_PAT;
                     ispattern <= 1'b1;
                     chardata <= pat_buf[0];
                  end
               end
            end
            SEND_STR: begin
               if (idx == str_len) begin
                  state <= GAP;
                  isstring <= 1'b0;
                  chardata <= 8'd0;
               end else begin
                  chardata <= str_buf[idx[SA-1:0]];
                  idx <= idx + SW'(1);
               end
            end
            // one idle cycle so the SME sees isstring fall before ispattern rises
            GAP: begin
               state <= SEND_PAT;
               ispattern <= 1'b1;
               chardata <= pat_buf[0];
               idx <= SW'(1);
            end
            SEND_PAT: begin
               if (idx == SW'(pat_len)) begin
                  state <= WAIT;
                  ispattern <= 1'b0;
                  chardata <= 8'd0;
`ifdef SME_FEEDER_TIMEOUT_EN
                  wcnt <= 7'd0;
`endif
               end else begin
                  chardata <= pat_buf[idx[PA-1:0]];
                  idx <= idx + SW'(1);
               end
            end
            WAIT: begin
               if (sme_valid) begin
                  state <= DONE;
                  res_valid <= 1'b1;
                  res_match <= sme_match;
                  res_index <= sme_index;
`ifdef SME_FEEDER_TIMEOUT_EN
                  res_timeout <= 1'b0;
               end else if (wcnt == 7'(TIMEOUT - 1)) begin
                  state <= DONE;
                  res_valid <= 1'b1;
                  res_match <= 1'b0;
                  res_index <= 5'd31;
                  res_timeout <= 1'b1;
               end else begin
                  wcnt <= wcnt + 7'd1;
`endif
               end
            end
            DONE: begin
               state <= IDLE;
               res_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sme_feeder.sv
// tb_sme_feeder: randomized self-checking bench for sme_feeder against a queue-based model
module tb_sme_feeder;
   logic clk = 1'b0;
   logic reset, str_we, pat_we, load_clr, start, sme_valid, sme_match;
   logic [7:0] wdata;
   logic [4:0] sme_index;
   logic busy, isstring, ispattern, res_valid, res_match, res_timeout;
   logic [7:0] chardata;
   logic [4:0] res_index;
   int checks = 0, errors = 0;
   logic [7:0] mstr[$], mpat[$];
   bit mdirty;
   logic mres_match;
   logic [4:0] mres_index;

   always #5 clk = ~clk;

   sme_feeder dut (
      .clk(clk), .reset(reset), .str_we(str_we), .pat_we(pat_we), .wdata(wdata),
      .load_clr(load_clr), .start(start), .busy(busy), .chardata(chardata),
      .isstring(isstring), .ispattern(ispattern), .sme_valid(sme_valid),
      .sme_match(sme_match), .sme_index(sme_index), .res_valid(res_valid),
      .res_match(res_match), .res_index(res_index), .res_timeout(res_timeout)
   );

   task automatic model_clear();
      mstr.delete();
      mpat.delete();
      mdirty = 0;
   endtask

   task automatic wr(input bit s, input logic [7:0] b);
      @(negedge clk);
      str_we = s;
      pat_we = !s;
      wdata = b;
      @(posedge clk);
      #1;
      str_we = 0;
      pat_we = 0;
      if (s) begin
         if (mstr.size() < 32) begin
            mstr.push_back(b);
            mdirty = 1;
         end
      end else if (mpat.size() < 8) mpat.push_back(b);
   endtask

   task automatic clr(input bit with_wr);
      @(negedge clk);
      load_clr = 1;
      str_we = with_wr;
      pat_we = with_wr;
      wdata = 8'hEE;
      @(posedge clk);
      #1;
      load_clr = 0;
      str_we = 0;
      pat_we = 0;
      model_clear();
   endtask

   // starts a transaction and checks every streamed cycle; returns at the first WAIT cycle
   task automatic stream();
      logic [7:0] ed[$];
      bit es[$], ep[$];
      if (mdirty && mstr.size() != 0) begin
         foreach (mstr[i]) begin
            ed.push_back(mstr[i]); es.push_back(1); ep.push_back(0);
         end
         ed.push_back(8'd0); es.push_back(0); ep.push_back(0);
         mdirty = 0;
      end
      foreach (mpat[i]) begin
         ed.push_back(mpat[i]); es.push_back(0); ep.push_back(1);
      end
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      foreach (ed[i]) begin
         checks++;
         if (busy !== 1'b1 || isstring !== es[i] || ispattern !== ep[i] || chardata !== ed[i]) begin
            errors++;
            $display("FAIL stream[%0d]: got busy=%b s=%b p=%b d=%h, expected busy=1 s=%b p=%b d=%h",
                     i, busy, isstring, ispattern, chardata, es[i], ep[i], ed[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b1 || isstring !== 1'b0 || ispattern !== 1'b0 || chardata !== 8'd0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_entry: got busy=%b s=%b p=%b d=%h rv=%b, expected busy=1 s=0 p=0 d=00 rv=0",
                  busy, isstring, ispattern, chardata, res_valid);
      end
   endtask

   task automatic respond(input int delay, input bit poke, input logic m, input logic [4:0] ix);
      for (int d = 0; d < delay; d++) begin
         if (poke) begin
            str_we = 1;
            pat_we = 1;
            wdata = 8'($urandom);
         end
         @(negedge clk);
         str_we = 0;
         pat_we = 0;
         checks++;
         if (busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold[%0d]: got busy=%b rv=%b, expected busy=1 rv=0", d, busy, res_valid);
         end
      end
      sme_valid = 1;
      sme_match = m;
      sme_index = ix;
      @(negedge clk);
      sme_valid = 0;
      sme_match = 0;
      sme_index = 0;
      mres_match = m;
      mres_index = ix;
      checks++;
      if (res_valid !== 1'b1 || res_match !== m || res_index !== ix || res_timeout !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL done: got rv=%b rm=%b ri=%0d rt=%b busy=%b, expected rv=1 rm=%b ri=%0d rt=0 busy=1",
                  res_valid, res_match, res_index, res_timeout, busy, m, ix);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || res_match !== m || res_index !== ix) begin
         errors++;
         $display("FAIL after_done: got rv=%b busy=%b rm=%b ri=%0d, expected rv=0 busy=0 rm=%b ri=%0d",
                  res_valid, busy, res_match, res_index, m, ix);
      end
   endtask

   task automatic test_reset();
      reset = 1; str_we = 0; pat_we = 0; wdata = 0; load_clr = 0; start = 0;
      sme_valid = 0; sme_match = 0; sme_index = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 0 || isstring !== 0 || ispattern !== 0 || chardata !== 0 || res_valid !== 0 ||
          res_match !== 0 || res_index !== 0 || res_timeout !== 0) begin
         errors++;
         $display("FAIL reset: got busy=%b s=%b p=%b d=%h rv=%b rm=%b ri=%0d rt=%b, expected all 0",
                  busy, isstring, ispattern, chardata, res_valid, res_match, res_index, res_timeout);
      end
      reset = 0;
      model_clear();
      mres_match = 0;
      mres_index = 0;
   endtask

   task automatic test_basic();
      wr(1, 8'h61); wr(1, 8'h62); wr(1, 8'h63); wr(1, 8'h64);
      wr(0, 8'h62); wr(0, 8'h63);
      stream();
      respond(3, 0, 1'b1, 5'd1);
   endtask

   task automatic test_retained();
      stream();
      respond(2, 0, 1'b0, 5'd7);
   endtask

   task automatic test_clear();
      wr(1, 8'h41); wr(1, 8'h42);
      clr(1);
      wr(0, 8'h5E); wr(0, 8'h64);
      stream();
      respond(1, 0, 1'b1, 5'd3);
   endtask

   task automatic test_saturate();
      clr(0);
      for (int i = 0; i < 33; i++) wr(1, 8'($urandom));
      for (int i = 0; i < 3; i++) wr(0, 8'($urandom));
      stream();
      respond(4, 0, 1'b1, 5'd31);
      clr(0);
      wr(0, 8'h2E); wr(0, 8'h2A); wr(0, 8'h24);
      for (int i = 0; i < 6; i++) wr(0, 8'($urandom));
      stream();
      respond(0, 0, 1'b0, 5'd0);
   endtask

   task automatic test_nostart_and_busy_writes();
      clr(0);
      wr(1, 8'h78);
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy !== 0 || isstring !== 0 || ispattern !== 0) begin
            errors++;
            $display("FAIL empty_pat_start[%0d]: got busy=%b s=%b p=%b, expected 0 0 0", i, busy, isstring, ispattern);
         end
         @(negedge clk);
      end
      wr(0, 8'h11); wr(0, 8'h22);
      stream();
      respond(5, 1, 1'b1, 5'd9);
      wr(1, 8'h79);
      stream();
      respond(2, 0, 1'b0, 5'd12);
   endtask

   task automatic test_spurious_valid();
      @(negedge clk);
      sme_valid = 1;
      sme_match = ~mres_match;
      sme_index = ~mres_index;
      @(negedge clk);
      sme_valid = 0;
      sme_match = 0;
      sme_index = 0;
      checks++;
      if (res_valid !== 0 || busy !== 0 || res_match !== mres_match || res_index !== mres_index) begin
         errors++;
         $display("FAIL idle_valid: got rv=%b busy=%b rm=%b ri=%0d, expected rv=0 busy=0 rm=%b ri=%0d",
                  res_valid, busy, res_match, res_index, mres_match, mres_index);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 10; k++) begin
         if ($urandom_range(0, 2) == 0) clr($urandom_range(0, 1) == 1);
         for (int i = $urandom_range(0, 6); i > 0; i--) wr(1, 8'($urandom));
         for (int i = $urandom_range(0, 3); i > 0; i--) wr(0, 8'($urandom));
         if (mpat.size() == 0) wr(0, 8'($urandom));
         stream();
         respond($urandom_range(0, 10), $urandom_range(0, 1) == 1, 1'($urandom), 5'($urandom));
      end
   endtask

   task automatic test_timeout();
      int n;
      clr(0);
      wr(0, 8'h33);
      stream();
`ifdef SME_FEEDER_TIMEOUT_EN
      n = 0;
      while (res_valid !== 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 64 || res_timeout !== 1 || res_match !== 0 || res_index !== 5'd31) begin
         errors++;
         $display("FAIL timeout: got wait=%0d rt=%b rm=%b ri=%0d, expected wait=64 rt=1 rm=0 ri=31",
                  n, res_timeout, res_match, res_index);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 0 || busy !== 0) begin
         errors++;
         $display("FAIL timeout_end: got rv=%b busy=%b, expected 0 0", res_valid, busy);
      end
      mres_match = 0;
      mres_index = 5'd31;
`else
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy === 1'b1 && res_valid === 1'b0) n++;
      end
      checks++;
      if (n != 100) begin
         errors++;
         $display("FAIL wait_forever: got %0d busy cycles without result, expected 100", n);
      end
      reset = 1;
      @(negedge clk);
      reset = 0;
      checks++;
      if (busy !== 0 || res_valid !== 0 || res_timeout !== 0) begin
         errors++;
         $display("FAIL wait_reset: got busy=%b rv=%b rt=%b, expected 0 0 0", busy, res_valid, res_timeout);
      end
      model_clear();
      mres_match = 0;
      mres_index = 0;
`endif
   endtask

   task automatic test_reset_mid();
      clr(0);
      for (int i = 0; i < 8; i++) wr(0, 8'($urandom));
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      checks++;
      if (ispattern !== 1 || chardata !== mpat[1]) begin
         errors++;
         $display("FAIL mid_send: got p=%b d=%h, expected p=1 d=%h", ispattern, chardata, mpat[1]);
      end
      reset = 1;
      @(negedge clk);
      reset = 0;
      checks++;
      if (busy !== 0 || isstring !== 0 || ispattern !== 0 || chardata !== 0 || res_valid !== 0) begin
         errors++;
         $display("FAIL mid_reset: got busy=%b s=%b p=%b d=%h rv=%b, expected all 0",
                  busy, isstring, ispattern, chardata, res_valid);
      end
      model_clear();
      mres_match = 0;
      mres_index = 0;
      wr(1, 8'h5A); wr(0, 8'hA5);
      stream();
      respond(1, 0, 1'b1, 5'd0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_retained();
      test_clear();
      test_saturate();
      test_nostart_and_busy_writes();
      test_spurious_valid();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
